// File: rtl/vlsu_seq_load.sv
// -----------------------------------------------------------------------------
// vlsu_seq_load
//   Sequential load path of the VLSU. Accepts one load request at a time
//   (destination vreg/areg and beat count), consumes AXI R-channel beats and
//   turns each beat into a lockstep VRF write to all lanes. Beats land on
//   consecutive VRF addresses {set, off} starting at the destination
//   register's base set.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   req_valid_i/req_ready_o  load request handshake (ready only when idle)
//   req_is_areg_i            destination is an accumulator register
//   req_reg_i                destination register index
//   req_nbeats_i             number of R beats to consume (0 allowed)
//   r_valid_i/r_ready_o      AXI R handshake
//   r_data_i, r_last_i       AXI R payload and RLAST
//   vrf_valid_o/vrf_ready_i  VRF write handshake, shared by all lanes
//   vrf_addr_o               {set, off} write address
//   vrf_data_o               write data; lane l takes slice l*LaneBits
//   done_o                   one-cycle completion pulse
//   err_o                    RLAST mismatch flag, valid with done_o
// -----------------------------------------------------------------------------
module vlsu_seq_load #(
  parameter int NrLanes    = 4,
  parameter int BusBits    = 512,
  parameter int NrBanks    = 4,
  parameter int NrVregs    = 16,
  parameter int NrAregs    = 16,
  parameter int SetPerVreg = 8,
  parameter int SetPerAreg = 16,
  // derived
  parameter int LaneBits     = BusBits / NrLanes,
  parameter int VAddrOffBits = $clog2(NrBanks),
  parameter int AregBaseSet  = NrVregs * SetPerVreg,
  parameter int NrSets       = AregBaseSet + NrAregs * SetPerAreg,
  parameter int VAddrSetBits = $clog2(NrSets),
  parameter int VAddrBits    = VAddrSetBits + VAddrOffBits,
  parameter int LenBits      = $clog2(SetPerAreg * NrBanks + 1),
  parameter int RegBits      = $clog2(NrVregs)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_is_areg_i,
  input  logic [RegBits-1:0]   req_reg_i,
  input  logic [LenBits-1:0]   req_nbeats_i,
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  input  logic [BusBits-1:0]   r_data_i,
  input  logic                 r_last_i,
  output logic                 vrf_valid_o,
  input  logic                 vrf_ready_i,
  output logic [VAddrBits-1:0] vrf_addr_o,
  output logic [BusBits-1:0]   vrf_data_o,
  output logic                 done_o,
  output logic                 err_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [VAddrBits-1:0]  r_addr;        // address of the next beat
  logic [LenBits-1:0]    r_remaining;   // beats still expected
  logic                  r_err;
  logic                  r_vrf_valid;
  logic [VAddrBits-1:0]  r_vrf_addr;
  logic [BusBits-1:0]    r_vrf_data;

  logic                    w_req_hs;
  logic                    w_r_ready;
  logic                    w_r_hs;
  logic                    w_vrf_acc;
  logic                    w_last_beat;
  logic                    w_done;
  logic [VAddrSetBits-1:0] w_base_set;
  logic [VAddrBits-1:0]    w_base_addr;

  assign w_base_set = req_is_areg_i
    ? VAddrSetBits'(AregBaseSet) + VAddrSetBits'(req_reg_i) * VAddrSetBits'(SetPerAreg)
    : VAddrSetBits'(req_reg_i) * VAddrSetBits'(SetPerVreg);
  assign w_base_addr = {w_base_set, {VAddrOffBits{1'b0}}};

  // Single-entry output register: a new beat may enter in the same cycle
  // the current one is accepted, so steady flow runs at one beat per cycle.
  assign w_r_ready   = (r_state == S_RUN) && (!r_vrf_valid || vrf_ready_i);
  assign w_req_hs    = req_valid_i && (r_state == S_IDLE);
  assign w_r_hs      = r_valid_i && w_r_ready;
  assign w_vrf_acc   = r_vrf_valid && vrf_ready_i;
  assign w_last_beat = (r_remaining == LenBits'(1));
  assign w_done      = (r_state == S_DONE) && !r_vrf_valid;

  assign req_ready_o = (r_state == S_IDLE);
  assign r_ready_o   = w_r_ready;
  assign vrf_valid_o = r_vrf_valid;
  assign vrf_addr_o  = r_vrf_addr;
  assign done_o      = w_done;
  assign err_o       = w_done && r_err;

  // The write data is broadcast unchanged; each lane owns one slice.
  for (genvar gi = 0; gi < NrLanes; gi++) begin : g_lane
    assign vrf_data_o[gi*LaneBits +: LaneBits] = r_vrf_data[gi*LaneBits +: LaneBits];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req_hs) begin
          w_state_next = (req_nbeats_i == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Either the expected last beat or an early RLAST ends consumption;
        // DONE then waits for the output register to drain.
        if (w_r_hs && (w_last_beat || r_last_i)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (w_done) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_err       <= 1'b0;
      r_vrf_valid <= 1'b0;
      r_vrf_addr  <= '0;
      r_vrf_data  <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_req_hs) begin
        r_addr      <= w_base_addr;
        r_remaining <= req_nbeats_i;
        r_err       <= 1'b0;
      end

      if (w_r_hs) begin
        r_vrf_valid <= 1'b1;
        r_vrf_addr  <= r_addr;
        r_vrf_data  <= r_data_i;
        // Plain increment: the offset wraps and carries into the set field.
        r_addr      <= r_addr + VAddrBits'(1);
        r_remaining <= r_remaining - LenBits'(1);
        if (w_last_beat) begin
          r_err <= r_err | ~r_last_i;
        end else if (r_last_i) begin
          r_err <= 1'b1;
        end
      end else if (w_vrf_acc) begin
        r_vrf_valid <= 1'b0;
      end

      if (w_done) begin
        r_err <= 1'b0;
      end
    end
  end

  // Requests larger than the destination register are illegal.
  a_nbeats_fit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_req_hs |-> (req_nbeats_i <= (req_is_areg_i ? LenBits'(SetPerAreg * NrBanks)
                                                 : LenBits'(SetPerVreg * NrBanks))));

endmodule

// File: tb/tb_vlsu_seq_load.sv
module tb_vlsu_seq_load;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_is_areg_i;
  logic [3:0]   req_reg_i;
  logic [6:0]   req_nbeats_i;
  logic         r_valid_i;
  logic         r_ready_o;
  logic [511:0] r_data_i;
  logic         r_last_i;
  logic         vrf_valid_o;
  logic         vrf_ready_i;
  logic [10:0]  vrf_addr_o;
  logic [511:0] vrf_data_o;
  logic         done_o;
  logic         err_o;

  always #5 clk_i = ~clk_i;

  vlsu_seq_load dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_is_areg_i (req_is_areg_i),
    .req_reg_i     (req_reg_i),
    .req_nbeats_i  (req_nbeats_i),
    .r_valid_i     (r_valid_i),
    .r_ready_o     (r_ready_o),
    .r_data_i      (r_data_i),
    .r_last_i      (r_last_i),
    .vrf_valid_o   (vrf_valid_o),
    .vrf_ready_i   (vrf_ready_i),
    .vrf_addr_o    (vrf_addr_o),
    .vrf_data_o    (vrf_data_o),
    .done_o        (done_o),
    .err_o         (err_o)
  );

  typedef struct {
    bit        is_areg;
    bit [3:0]  rg;
    int        nbeats;
    int        last_at;     // beat number (1-based) carrying RLAST, 0 = never
    int        stall_beat;  // write index held off by vrf_ready_i
    int        stall_len;   // stall cycles, 0 = none
    bit [10:0] base_addr;   // hand-computed first VRF address
    int        exp_writes;
    bit        exp_err;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] mk_data(input int txn, input int idx);
    logic [511:0] d;
    for (int w = 0; w < 16; w++) begin
      d[w*32 +: 32] = {8'(txn), 8'(idx), 16'(w) ^ 16'hA5C3};
    end
    return d;
  endfunction

  task automatic issue_req(input bit is_areg, input bit [3:0] rg, input int nbeats);
    @(negedge clk_i);
    req_valid_i   = 1'b1;
    req_is_areg_i = is_areg;
    req_reg_i     = rg;
    req_nbeats_i  = 7'(nbeats);
    r_valid_i     = 1'b0;
    r_last_i      = 1'b0;
    vrf_ready_i   = 1'b1;
    #1;
    chk("req_ready", {511'd0, req_ready_o}, 512'd1);
  endtask

  task automatic run_txn(input int t, input vec_t v);
    logic [511:0] q[$];
    logic [511:0] exp_d;
    logic [10:0]  held_addr;
    logic [511:0] held_data;
    int  wr = 0, sent = 0, done_cnt = 0, done_cyc = 0;
    int  first_wr = 0, last_wr = 0, stall_cnt = 0;
    bit  stall;
    issue_req(v.is_areg, v.rg, v.nbeats);
    for (int cyc = 0; cyc < 400 && done_cnt == 0; cyc++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      stall       = vrf_valid_o && (wr == v.stall_beat) && (stall_cnt < v.stall_len);
      vrf_ready_i = !stall;
      r_valid_i   = 1'b1;
      r_data_i    = mk_data(t, sent);
      r_last_i    = (v.last_at != 0) && (sent + 1 == v.last_at);
      #1;
      if (stall) begin
        stall_cnt++;
        chk("stall_r_ready", {511'd0, r_ready_o}, 512'd0);
        if (stall_cnt > 1) begin
          chk("stall_addr", {501'd0, vrf_addr_o}, {501'd0, held_addr});
          chk("stall_data", vrf_data_o, held_data);
        end
      end
      held_addr = vrf_addr_o;
      held_data = vrf_data_o;
      if (vrf_valid_o && vrf_ready_i) begin
        if (q.size() == 0) begin
          chk("spurious_write", 512'd1, 512'd0);
        end else begin
          exp_d = q.pop_front();
          chk("wr_addr", {501'd0, vrf_addr_o}, {501'd0, v.base_addr + 11'(wr)});
          chk("wr_data", vrf_data_o, exp_d);
          chk("wr_lane2", {384'd0, vrf_data_o[383:256]}, {384'd0, exp_d[383:256]});
        end
        if (wr == 0) first_wr = cyc;
        last_wr = cyc;
        wr++;
      end
      if (r_valid_i && r_ready_o) begin
        q.push_back(r_data_i);
        sent++;
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc;
        chk("err", {511'd0, err_o}, {511'd0, v.exp_err});
      end
    end
    chk("done_seen", 512'(done_cnt), 512'd1);
    chk("writes", 512'(wr), 512'(v.exp_writes));
    chk("beats_taken", 512'(sent), 512'(v.exp_writes));
    if (wr > 0) chk("done_latency", 512'(done_cyc - last_wr), 512'd1);
    if (wr > 0 && v.stall_len == 0) chk("throughput", 512'(last_wr - first_wr), 512'(wr - 1));
    @(negedge clk_i);
    r_valid_i = 1'b0;
    r_last_i  = 1'b0;
    #1;
    chk("done_pulse_end", {511'd0, done_o}, 512'd0);
    chk("idle_ready", {511'd0, req_ready_o}, 512'd1);
    $display("txn %0d: %s %0d nbeats=%0d writes=%0d err=%0b", t,
             v.is_areg ? "areg" : "vreg", v.rg, v.nbeats, wr, v.exp_err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {511'd0, req_ready_o}, 512'd1);
    chk({tag, "_r_ready"},   {511'd0, r_ready_o},   512'd0);
    chk({tag, "_vrf_valid"}, {511'd0, vrf_valid_o}, 512'd0);
    chk({tag, "_vrf_addr"},  {501'd0, vrf_addr_o},  512'd0);
    chk({tag, "_vrf_data"},  vrf_data_o,            512'd0);
    chk({tag, "_done"},      {511'd0, done_o},      512'd0);
    chk({tag, "_err"},       {511'd0, err_o},       512'd0);
  endtask

  vec_t vecs[9];

  initial begin
    //            areg rg  n   last stb stl base     wr err
    vecs[0] = '{1'b0, 3,  4,  4,  0, 0, 11'h060, 4,  1'b0};
    vecs[1] = '{1'b1, 1,  6,  6,  0, 0, 11'h240, 6,  1'b0};
    vecs[2] = '{1'b0, 0,  3,  3,  1, 5, 11'h000, 3,  1'b0};
    vecs[3] = '{1'b0, 5,  4,  2,  0, 0, 11'h0A0, 2,  1'b1};
    vecs[4] = '{1'b0, 2,  4,  4,  0, 0, 11'h040, 4,  1'b0};
    vecs[5] = '{1'b1, 15, 2,  0,  0, 0, 11'h5C0, 2,  1'b1};
    vecs[6] = '{1'b0, 7,  0,  0,  0, 0, 11'h000, 0,  1'b0};
    vecs[7] = '{1'b0, 15, 32, 32, 0, 0, 11'h1E0, 32, 1'b0};
    vecs[8] = '{1'b1, 0,  64, 64, 0, 0, 11'h200, 64, 1'b0};

    rst_ni        = 1'b0;
    req_valid_i   = 1'b0;
    req_is_areg_i = 1'b0;
    req_reg_i     = '0;
    req_nbeats_i  = '0;
    r_valid_i     = 1'b0;
    r_data_i      = '0;
    r_last_i      = 1'b0;
    vrf_ready_i   = 1'b1;

    repeat (2) @(negedge clk_i);
    #1;
    chk_reset_outputs("rst");
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_txn(i, vecs[i]);
    end

    // Reset while a beat sits stalled in the output register.
    issue_req(1'b0, 4'd1, 8);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      req_valid_i = 1'b0;
      vrf_ready_i = 1'b0;
      r_valid_i   = 1'b1;
      r_data_i    = mk_data(99, c);
    end
    #1;
    chk("pre_rst_vrf_valid", {511'd0, vrf_valid_o}, 512'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk_i);
    rst_ni      = 1'b1;
    r_valid_i   = 1'b0;
    vrf_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      #1;
      chk("post_rst_done", {511'd0, done_o}, 512'd0);
      chk("post_rst_valid", {511'd0, vrf_valid_o}, 512'd0);
    end

    // Normal operation resumes after the reset.
    run_txn(9, vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vlsu_seq_load.md
Name: vlsu_seq_load

Overview:
- Load-side counterpart of the VLSU sequential store path: accepts one load request (destination vreg/areg, beat count), consumes AXI R-channel beats and emits lockstep VRF write requests to all lanes.
- Beats map to consecutive VRF addresses {set, off} starting at the destination register's base set.
- Sits between the AXI read port and the per-lane VRF write arbiters; one request in flight at a time.

Parameters:
NrLanes, 4, lanes written in lockstep
BusBits, 512, AXI data width; LaneBits = BusBits/NrLanes = 128
NrBanks, 4, VRF banks per lane; VAddrOffBits = clog2(NrBanks) = 2
NrVregs, 16, vector registers
NrAregs, 16, matrix/accumulator registers
SetPerVreg, 8, sets per vreg
SetPerAreg, 16, sets per areg
Derived: AregBaseSet = NrVregs*SetPerVreg = 128; NrSets = 384; VAddrSetBits = 9; VAddrBits = 11; LenBits = clog2(SetPerAreg*NrBanks+1) = 7

Ports:
clk_i  in  1  clock
rst_ni  in  1  async active-low reset
req_valid_i  in  1  load request valid
req_ready_o  out  1  high only in IDLE
req_is_areg_i  in  1  1: destination is areg
req_reg_i  in  4  destination register index
req_nbeats_i  in  7  beats to receive (0..64)
r_valid_i  in  1  AXI R beat valid
r_ready_o  out  1  AXI R ready
r_data_i  in  BusBits  beat data
r_last_i  in  1  AXI RLAST
vrf_valid_o  out  1  VRF write valid (all lanes)
vrf_ready_i  in  1  all lanes accept
vrf_addr_o  out  11  {set[8:0], off[1:0]}
vrf_data_o  out  BusBits  lane l gets bits [l*128 +: 128]
done_o  out  1  one-cycle completion pulse
err_o  out  1  valid with done_o: RLAST mismatch

Behaviour:
- Reset (async assert, sync deassert by the integrator): state IDLE, req_ready_o=1, r_ready_o=0, vrf_valid_o=0, vrf_addr_o=0, vrf_data_o=0, done_o=0, err_o=0, counters 0.
- States: IDLE, RUN, DONE.
- IDLE: on req_valid_i & req_ready_o, latch request; base = is_areg ? AregBaseSet + reg*SetPerAreg : reg*SetPerVreg; addr_q = base*NrBanks (11-bit); remaining = nbeats. nbeats=0 -> DONE directly (no beat consumed), else RUN.
- RUN: output register is a single entry; r_ready_o = !vrf_valid_o | vrf_ready_i (no bubble under continuous flow, full throughput 1 beat/cycle).
- On R handshake: vrf_valid_o<=1, vrf_data_o<=r_data_i, vrf_addr_o<=addr_q; addr_q+=1 (off wraps 3->0 and carries into set); remaining-=1.
- Output clear: vrf_ready_i & vrf_valid_o with no new R handshake same cycle -> vrf_valid_o<=0. Simultaneous accept + new beat -> register reloads, stays valid.
- Last beat (remaining==1 at handshake): err_q |= !r_last_i; go DONE once output drains.
- Early RLAST (r_last_i on beat with remaining>1): err_q=1, beat still written, stop consuming (r_ready_o=0), go DONE after drain.
- DONE: wait until vrf_valid_o=0, then pulse done_o=1 and err_o=err_q for exactly one cycle, clear err_q, return to IDLE (req_ready_o=1 next cycle).
- vrf_valid_o/addr/data held stable while vrf_valid_o & !vrf_ready_i.
- Requests with nbeats > register capacity (32 vreg, 64 areg) are illegal; simulation assertion fires. Address arithmetic is not clamped.
- Reset mid-RUN discards pending beat and request; no done_o.
- R beats arriving in IDLE/DONE are not accepted (r_ready_o=0).

Test Plan:
- vreg 3, nbeats=4, R beats every cycle, vrf_ready_i=1 -> vrf_addr_o 0x60,0x61,0x62,0x63 on consecutive cycles, done_o 1 cycle after last write accepted, err_o=0.
- areg 1, nbeats=6 -> addr base set 144: 0x240..0x245 (off wraps at 0x243->0x244), data lane 2 equals r_data_i[383:256].
- vreg 0, nbeats=3, vrf_ready_i low 5 cycles on beat 1 -> r_ready_o low during stall, vrf_addr_o/data stable, no beat lost, 3 writes total.
- nbeats=4, r_last_i on beat 2 -> 2 writes, r_ready_o drops, done_o with err_o=1; next request accepted normally with err_o=0.
- nbeats=2, no r_last_i on beat 2 -> 2 writes, done_o with err_o=1.
- nbeats=0 -> no R handshake, done_o exactly 1 pulse; rst_ni asserted mid-RUN -> all outputs reset values, req_ready_o=1.
